// File: rtl/common_pkg.sv
// Shared types for the video subsystem: raster command encoding and the
// command-queue entry/state types used between vgacpu and rasterizer.
package common;

   // Raster operations understood by the rasterizer.
   typedef enum logic [2:0] {
      RC_NOP       = 3'd0,
      RC_CLEAR     = 3'd1,
      RC_PIXEL     = 3'd2,
      RC_LINE      = 3'd3,
      RC_RECT      = 3'd4,
      RC_RECT_FILL = 3'd5
   } raster_command_t;

   localparam int GPU_CMD_QUEUE_DEPTH_DEFAULT = 8;

   // One queued draw: opcode, two corner points and a 3-bit colour.
   typedef struct packed {
      raster_command_t command;
      logic [7:0]      x0;
      logic [7:0]      y0;
      logic [7:0]      x1;
      logic [7:0]      y1;
      logic [2:0]      colour;
   } gpu_cmd_entry_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } gpu_cmd_queue_state_t;

endpackage

// File: rtl/gpu_cmd_queue_sync_fifo.sv
// Generic synchronous FIFO with registered level/full and a flush input.
// Pointers wrap modulo DEPTH (power of two). Pushes while full and pops
// while empty are ignored; flush wins over both in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       level_nxt;
   logic              do_push;
   logic              do_pop;

   assign do_push = push & ~full  & ~flush;
   assign do_pop  = pop  & ~empty & ~flush;
   assign empty   = (level == '0);
   assign dout    = mem[rd_ptr];

   // Next occupancy: flush clears, simultaneous push+pop leaves it unchanged.
   always_comb begin
      level_nxt = level;
      if (flush)
         level_nxt = '0;
      else if (do_push && !do_pop)
         level_nxt = level + LVL_ONE;
      else if (do_pop && !do_push)
         level_nxt = level - LVL_ONE;
   end

   // Pointer, level and full-flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         end
         level <= level_nxt;
         full  <= (level_nxt == LVL_FULL);
      end
   end

   // Storage array; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/gpu_cmd_queue.sv
// CPU-to-rasterizer command scheduler. Queues raster commands from the CPU
// and replays them one at a time on the execute_request/busy handshake.
// Optional macro GPU_CMD_QUEUE_STATS_EN adds saturating issue/timeout counters.
module gpu_cmd_queue
   import common::*;
#(
   parameter int DEPTH       = GPU_CMD_QUEUE_DEPTH_DEFAULT,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                    clk,
   input  logic                    rst_sync,
   input  raster_command_t         cpu_command,
   input  logic [7:0]              cpu_x0,
   input  logic [7:0]              cpu_y0,
   input  logic [7:0]              cpu_x1,
   input  logic [7:0]              cpu_y1,
   input  logic [2:0]              cpu_colour,
   input  logic                    cpu_push,
   input  logic                    cpu_flush,
   output logic                    cpu_full,
   output logic [$clog2(DEPTH):0]  cpu_level,
   output logic                    cpu_overflow,
   output logic                    cpu_idle,
   output raster_command_t         command,
   output logic [7:0]              x0,
   output logic [7:0]              y0,
   output logic [7:0]              x1,
   output logic [7:0]              y1,
   output logic [2:0]              colour,
   output logic                    execute_request,
   input  logic                    busy
`ifdef GPU_CMD_QUEUE_STATS_EN
   ,
   output logic [15:0]             stat_issued,
   output logic [15:0]             stat_timeouts
`endif
);

   localparam int ENTRY_W = $bits(gpu_cmd_entry_t);
   localparam int CW      = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   gpu_cmd_queue_state_t state;
   gpu_cmd_queue_state_t state_nxt;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_nxt;
   gpu_cmd_entry_t       push_entry;
   gpu_cmd_entry_t       head_entry;
   logic [ENTRY_W-1:0]   fifo_dout;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic                 timeout_exit;

   assign push_entry = '{cpu_command, cpu_x0, cpu_y0, cpu_x1, cpu_y1, cpu_colour};
   assign head_entry = gpu_cmd_entry_t'(fifo_dout);

   sync_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst_sync),
      .push  (cpu_push),
      .pop   (fifo_pop),
      .flush (cpu_flush),
      .din   (push_entry),
      .dout  (fifo_dout),
      .full  (cpu_full),
      .empty (fifo_empty),
      .level (cpu_level)
   );

   assign cpu_idle = fifo_empty & (state == IDLE) & ~busy;

   // Sticky overflow: a push dropped because the queue was full. Flush clears
   // it and also swallows a same-cycle push without flagging it.
   always_ff @(posedge clk) begin
      if (rst_sync)
         cpu_overflow <= 1'b0;
      else if (cpu_flush)
         cpu_overflow <= 1'b0;
      else if (cpu_push && cpu_full)
         cpu_overflow <= 1'b1;
   end

   // State and acknowledge-timeout counter registers.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Handshake sequencing: load head in IDLE, request in ISSUE until busy is
   // seen (or the timeout expires), then wait for the rasterizer to finish.
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = '0;
      fifo_pop        = 1'b0;
      timeout_exit    = 1'b0;
      execute_request = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty && !busy && !cpu_flush) begin
               fifo_pop  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            execute_request = 1'b1;
            cnt_nxt         = cnt + CNT_ONE;
            if (busy) begin
               state_nxt = WAIT_DONE;
            end else if (cnt == TO_LAST) begin
               state_nxt    = IDLE;
               timeout_exit = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command fields presented to the rasterizer; held between issues.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         command <= RC_NOP;
         x0      <= '0;
         y0      <= '0;
         x1      <= '0;
         y1      <= '0;
         colour  <= '0;
      end else if (fifo_pop) begin
         command <= head_entry.command;
         x0      <= head_entry.x0;
         y0      <= head_entry.y0;
         x1      <= head_entry.x1;
         y1      <= head_entry.y1;
         colour  <= head_entry.colour;
      end
   end

`ifdef GPU_CMD_QUEUE_STATS_EN
   // Saturating counters of issued commands and timeout completions.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         stat_issued   <= '0;
         stat_timeouts <= '0;
      end else begin
         if (fifo_pop && stat_issued != 16'hFFFF)
            stat_issued <= stat_issued + 16'd1;
         if (timeout_exit && stat_timeouts != 16'hFFFF)
            stat_timeouts <= stat_timeouts + 16'd1;
      end
   end
`endif

endmodule
